// File: rtl/traffic_lamp_monitor_pkg.sv
// Shared definitions for the traffic lamp monitor: FSM encoding, approach pair masks
// and fault-code bit positions.
package traffic_pkg;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        CONFIRM = 2'd1,
        FLASH   = 2'd2
    } mon_state_t;

    localparam logic [3:0] PAIR_A = 4'b0011;
    localparam logic [3:0] PAIR_B = 4'b1100;

    localparam int FC_INV = 0;
    localparam int FC_CFL = 1;
    localparam int FC_MIS = 2;

    localparam logic [3:0] ALL_ON  = 4'hF;
    localparam logic [3:0] ALL_OFF = 4'h0;

    function automatic logic is_one_hot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/traffic_lamp_monitor_if.sv
// Lamp bus between the light controller (master) and the lamp monitor (slave).
interface traffic_lamp_monitor_if;
    logic [3:0] r_in;
    logic [3:0] y_in;
    logic [3:0] g_in;
    logic       clear_fault;
    logic [3:0] r_out;
    logic [3:0] y_out;
    logic [3:0] g_out;
    logic       fault_active;
    logic [2:0] fault_code;

    modport master (
        output r_in, y_in, g_in, clear_fault,
        input  r_out, y_out, g_out, fault_active, fault_code
    );

    modport slave (
        input  r_in, y_in, g_in, clear_fault,
        output r_out, y_out, g_out, fault_active, fault_code
    );
endinterface

// File: rtl/traffic_lamp_monitor_lamp_flasher.sv
// Phase counter for the fail-safe flash: on for the first HALF cycles of every
// 2*HALF period while enabled; held at phase 0 while disabled.
module lamp_flasher #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic on
);
    localparam int PW = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;
    localparam logic [PW-1:0] LAST = PW'(2 * HALF - 1);

    logic [PW-1:0] phase;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            phase <= '0;
        end else if (phase == LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    assign on = (int'(phase) < HALF);
endmodule

// File: rtl/traffic_lamp_monitor.sv
// Lamp sanity monitor: registers valid lamp patterns through, forces all-red on a
// suspected fault and latches a flashing-yellow fail-safe once the fault is confirmed.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int CONFIRM_CYCLES = 2,
    parameter int FLASH_HALF     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    traffic_lamp_monitor_if.slave  lamps
);
    localparam int CW = $clog2(CONFIRM_CYCLES + 1);

    mon_state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0] code, code_next;
    logic [3:0] r_q, y_q, g_q, r_next, y_next, g_next;
    logic fa_q;

    logic inv, cfl, mis, flt, leave, flash_on, flash_en;
    logic [2:0] causes;
    logic [3:0] busy;

    always_comb begin
        inv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!is_one_hot3({lamps.r_in[i], lamps.y_in[i], lamps.g_in[i]})) inv = 1'b1;
        end
    end

    assign busy = lamps.g_in | lamps.y_in;
    assign cfl  = (|(busy & PAIR_A)) && (|(busy & PAIR_B));
    assign mis  = ({lamps.r_in[0], lamps.y_in[0], lamps.g_in[0]} !=
                   {lamps.r_in[1], lamps.y_in[1], lamps.g_in[1]}) ||
                  ({lamps.r_in[2], lamps.y_in[2], lamps.g_in[2]} !=
                   {lamps.r_in[3], lamps.y_in[3], lamps.g_in[3]});
    assign flt  = inv | cfl | mis;

    always_comb begin
        causes         = 3'b000;
        causes[FC_INV] = inv;
        causes[FC_CFL] = cfl;
        causes[FC_MIS] = mis;
    end

    // A clear request only counts when the lamps it would release are sane.
    assign leave    = lamps.clear_fault && !flt;
    assign flash_en = (state == FLASH) && !leave;

    lamp_flasher #(.HALF(FLASH_HALF)) u_flasher (
        .clk   (clk),
        .reset (reset),
        .en    (flash_en),
        .on    (flash_on)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = code;
        r_next     = r_q;
        y_next     = y_q;
        g_next     = g_q;
        case (state)
            PASS: begin
                if (flt) begin
                    r_next     = ALL_ON;
                    y_next     = ALL_OFF;
                    g_next     = ALL_OFF;
                    code_next  = code | causes;
                    cnt_next   = CW'(1);
                    state_next = (CONFIRM_CYCLES == 1) ? FLASH : CONFIRM;
                end else begin
                    r_next = lamps.r_in;
                    y_next = lamps.y_in;
                    g_next = lamps.g_in;
                end
            end
            CONFIRM: begin
                if (flt) begin
                    r_next    = ALL_ON;
                    y_next    = ALL_OFF;
                    g_next    = ALL_OFF;
                    code_next = code | causes;
                    cnt_next  = cnt + CW'(1);
                    if (int'(cnt) + 1 >= CONFIRM_CYCLES) state_next = FLASH;
                end else begin
                    r_next     = lamps.r_in;
                    y_next     = lamps.y_in;
                    g_next     = lamps.g_in;
                    code_next  = 3'b000;
                    cnt_next   = '0;
                    state_next = PASS;
                end
            end
            FLASH: begin
                cnt_next = '0;
                if (leave) begin
                    r_next     = ALL_ON;
                    y_next     = ALL_OFF;
                    g_next     = ALL_OFF;
                    code_next  = 3'b000;
                    state_next = PASS;
                end else begin
                    r_next    = ALL_OFF;
                    g_next    = ALL_OFF;
                    y_next    = flash_on ? ALL_ON : ALL_OFF;
                    code_next = code | causes;
                end
            end
            default: state_next = PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PASS;
            cnt   <= '0;
            code  <= 3'b000;
            r_q   <= ALL_ON;
            y_q   <= ALL_OFF;
            g_q   <= ALL_OFF;
            fa_q  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            code  <= code_next;
            r_q   <= r_next;
            y_q   <= y_next;
            g_q   <= g_next;
            fa_q  <= (state_next != PASS);
        end
    end

    assign lamps.r_out        = r_q;
    assign lamps.y_out        = y_q;
    assign lamps.g_out        = g_q;
    assign lamps.fault_active = fa_q;
    assign lamps.fault_code   = code;
endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Scoreboard bench for traffic_lamp_monitor: a behavioural lamp-rule model predicts
// each registered output; a monitor process compares one cycle later.
module tb_traffic_lamp_monitor;
    localparam int CONFIRM_CYCLES = 2;
    localparam int FLASH_HALF     = 4;

    logic clk;
    logic reset;

    traffic_lamp_monitor_if bus ();

    traffic_lamp_monitor #(
        .CONFIRM_CYCLES (CONFIRM_CYCLES),
        .FLASH_HALF     (FLASH_HALF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .lamps (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] r;
        logic [3:0] y;
        logic [3:0] g;
        logic       fa;
        logic [2:0] code;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Legal controller phases: g1g2/r3r4, y1y2/r3r4, r1r2/g3g4, r1r2/y3y4.
    logic [3:0] leg_r [4] = '{4'b1100, 4'b1100, 4'b0011, 4'b0011};
    logic [3:0] leg_y [4] = '{4'b0000, 4'b0011, 4'b0000, 4'b1100};
    logic [3:0] leg_g [4] = '{4'b0011, 4'b0000, 4'b1100, 4'b0000};

    // Reference model: consecutive faulty cycles, flash latch, cycles spent flashing.
    int         m_run = 0;
    bit         m_flashing = 1'b0;
    int         m_fidx = 0;
    logic [2:0] m_code = 3'b000;

    function automatic logic [2:0] causes_of(input logic [3:0] r, input logic [3:0] y,
                                             input logic [3:0] g);
        logic [2:0] c;
        int lit;
        c = 3'b000;
        for (int i = 0; i < 4; i++) begin
            lit = int'(r[i]) + int'(y[i]) + int'(g[i]);
            if (lit != 1) c[0] = 1'b1;
        end
        c[1] = (((g | y) & 4'b0011) != 4'b0000) && (((g | y) & 4'b1100) != 4'b0000);
        c[2] = (r[0] != r[1]) || (y[0] != y[1]) || (g[0] != g[1]) ||
               (r[2] != r[3]) || (y[2] != y[3]) || (g[2] != g[3]);
        return c;
    endfunction

    task automatic apply(input logic [3:0] r, input logic [3:0] y, input logic [3:0] g,
                         input logic clr, input logic rst);
        exp_t e;
        logic [2:0] why;
        @(negedge clk);
        bus.r_in = r;
        bus.y_in = y;
        bus.g_in = g;
        bus.clear_fault = clr;
        reset = rst;
        why = causes_of(r, y, g);
        if (rst) begin
            m_run = 0; m_flashing = 1'b0; m_fidx = 0; m_code = 3'b000;
            e = '{r: 4'hF, y: 4'h0, g: 4'h0, fa: 1'b0, code: 3'b000};
        end else if (m_flashing) begin
            if (clr && why == 3'b000) begin
                m_flashing = 1'b0; m_run = 0; m_code = 3'b000;
                e = '{r: 4'hF, y: 4'h0, g: 4'h0, fa: 1'b0, code: 3'b000};
            end else begin
                m_code = m_code | why;
                e = '{r: 4'h0, y: (((m_fidx / FLASH_HALF) % 2) == 0) ? 4'hF : 4'h0,
                      g: 4'h0, fa: 1'b1, code: m_code};
                m_fidx++;
            end
        end else if (why != 3'b000) begin
            m_run++;
            m_code = m_code | why;
            if (m_run >= CONFIRM_CYCLES) begin
                m_flashing = 1'b1;
                m_fidx = 0;
                m_run = 0;
            end
            e = '{r: 4'hF, y: 4'h0, g: 4'h0, fa: 1'b1, code: m_code};
        end else begin
            m_run = 0;
            m_code = 3'b000;
            e = '{r: r, y: y, g: g, fa: 1'b0, code: 3'b000};
        end
        exp_q.push_back(e);
    endtask

    task automatic legal(input int ph, input logic clr);
        apply(leg_r[ph], leg_y[ph], leg_g[ph], clr, 1'b0);
    endtask

    // Monitor: every output cycle that has a prediction waiting is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (bus.r_out !== e.r || bus.y_out !== e.y || bus.g_out !== e.g ||
                    bus.fault_active !== e.fa || bus.fault_code !== e.code) begin
                    miscompares++;
                    $display("FAIL lamps @%0t: got r=%h y=%h g=%h fa=%b code=%b, want r=%h y=%h g=%h fa=%b code=%b",
                             $time, bus.r_out, bus.y_out, bus.g_out, bus.fault_active,
                             bus.fault_code, e.r, e.y, e.g, e.fa, e.code);
                end
            end
        end
    end

    initial begin
        int ph;
        int sel;
        logic clr;
        reset = 1'b1;
        bus.r_in = 4'hF;
        bus.y_in = 4'h0;
        bus.g_in = 4'h0;
        bus.clear_fault = 1'b0;

        apply(4'hF, 4'h0, 4'h0, 1'b0, 1'b1);
        apply(4'hF, 4'h0, 4'h0, 1'b0, 1'b1);

        for (int c = 0; c < 3; c++)
            for (int p = 0; p < 4; p++) begin
                legal(p, 1'b0);
                legal(p, 1'b0);
            end

        apply(4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) legal(0, 1'b0);

        for (int k = 0; k < 14; k++) apply(4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
        apply(4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
        apply(4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
        apply(4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
        legal(2, 1'b1);
        for (int k = 0; k < 4; k++) legal(2, 1'b0);

        for (int k = 0; k < 8; k++) apply(4'b0001, 4'h0, 4'b0001, 1'b0, 1'b0);
        apply(4'b0001, 4'h0, 4'b0001, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) legal(0, 1'b0);

        ph = 0;
        for (int k = 0; k < 500; k++) begin
            sel = int'($urandom_range(0, 99));
            clr = ($urandom_range(0, 7) == 0);
            if (sel < 2) begin
                apply(4'hF, 4'h0, 4'h0, clr, 1'b1);
            end else if (sel < 14) begin
                apply(4'($urandom), 4'($urandom), 4'($urandom), clr, 1'b0);
            end else begin
                if ($urandom_range(0, 2) == 0) ph = (ph + 1) % 4;
                legal(ph, clr);
            end
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
